// File: rtl/siso_shift_register.sv
// siso_shift_register: serial-in serial-out right-shift delay line.
// Ports: clk, rst (sync, active-high), si -> so, rshift[WIDTH-1:0].
module siso_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  output logic             so,
  output logic [WIDTH-1:0] rshift
);

  logic [WIDTH-1:0] rshift_q;
  logic [WIDTH-1:0] rshift_d;

  // Bitwise form so WIDTH=1 needs no empty slice.
  always_comb begin
    rshift_d = rshift_q;
    rshift_d[WIDTH-1] = si;
    for (int i = 0; i < WIDTH - 1; i++) begin
      rshift_d[i] = rshift_q[i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rshift_q <= '0;
    end else begin
      rshift_q <= rshift_d;
    end
  end

  assign rshift = rshift_q;
  assign so     = rshift_q[0];

endmodule

// File: tb/tb_siso_shift_register.sv
// tb_siso_shift_register: directed checks of the 4-stage delay line.
// Inputs change on the falling edge; outputs sampled 1 after rising edge.
module tb_siso_shift_register;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         si;
  logic         so;
  logic [W-1:0] rshift;

  int n_pass;
  int n_total;

  siso_shift_register #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .si    (si),
    .so    (so),
    .rshift(rshift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string  tag,
    input [W-1:0] exp_rs,
    input logic   exp_so
  );
    n_total++;
    assert (rshift === exp_rs) n_pass++;
    else $error("FAIL %s rshift got=%b exp=%b", tag, rshift, exp_rs);
    n_total++;
    assert (so === exp_so) n_pass++;
    else $error("FAIL %s so got=%b exp=%b", tag, so, exp_so);
  endtask

  task automatic step(
    input logic   r,
    input logic   s,
    input string  tag,
    input [W-1:0] exp_rs,
    input logic   exp_so
  );
    @(negedge clk);
    rst = r;
    si  = s;
    @(posedge clk);
    #1;
    check(tag, exp_rs, exp_so);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    si  = 1'b0;

    step(1'b1, 1'b0, "reset", 4'b0000, 1'b0);

    step(1'b0, 1'b0, "seq0", 4'b0000, 1'b0);
    step(1'b0, 1'b1, "seq1", 4'b1000, 1'b0);
    step(1'b0, 1'b1, "seq2", 4'b1100, 1'b0);
    step(1'b0, 1'b0, "seq3", 4'b0110, 1'b0);
    step(1'b0, 1'b1, "seq4", 4'b1011, 1'b1);
    step(1'b0, 1'b1, "seq5", 4'b1101, 1'b1);

    step(1'b1, 1'b1, "mid_rst", 4'b0000, 1'b0);
    step(1'b0, 1'b1, "post_rst", 4'b1000, 1'b0);

    step(1'b1, 1'b0, "lat_rst", 4'b0000, 1'b0);
    step(1'b0, 1'b1, "lat1", 4'b1000, 1'b0);
    step(1'b0, 1'b0, "lat2", 4'b0100, 1'b0);
    step(1'b0, 1'b0, "lat3", 4'b0010, 1'b0);
    step(1'b0, 1'b0, "lat4", 4'b0001, 1'b1);
    step(1'b0, 1'b0, "lat5", 4'b0000, 1'b0);

    step(1'b1, 1'b0, "ones_rst", 4'b0000, 1'b0);
    step(1'b0, 1'b1, "ones1", 4'b1000, 1'b0);
    step(1'b0, 1'b1, "ones2", 4'b1100, 1'b0);
    step(1'b0, 1'b1, "ones3", 4'b1110, 1'b0);
    step(1'b0, 1'b1, "ones4", 4'b1111, 1'b1);
    step(1'b0, 1'b1, "ones5", 4'b1111, 1'b1);

    // rst pulse and si toggles wholly between edges must not disturb state
    @(negedge clk);
    si  = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1 si  = 1'b1;
    #1 si  = 1'b0;
    check("glitch_hold", 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    check("glitch_edge1", 4'b0111, 1'b1);
    step(1'b0, 1'b0, "glitch_edge2", 4'b0011, 1'b1);
    step(1'b0, 1'b1, "glitch_edge3", 4'b1001, 1'b1);
    step(1'b0, 1'b0, "glitch_edge4", 4'b0100, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/siso_shift_register.md
# siso_shift_register

Serial-in, serial-out right-shift register with a parallel observation tap. Each clock it shifts one serial input bit in at the MSB end of a WIDTH-bit register and presents the LSB as the serial output. It serves as a fixed-latency bit delay line and serial buffer between bit-serial stages. The full register contents are exposed for monitoring.

## Interface
- WIDTH, default 4: number of register stages; also the serial latency in clock cycles; minimum 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- si  input  1  serial data in; sampled on each rising clk edge.
- so  output  1  serial data out; always equal to rshift[0].
- rshift  output  WIDTH  parallel view of the register; rshift[WIDTH-1] holds the most recently sampled bit.

## Operation
- Storage is a single WIDTH-bit register, rshift.
- On a rising edge with rst=1: rshift <= 0. so therefore reads 0. si is ignored on that edge.
- On a rising edge with rst=0: rshift <= {si, rshift[WIDTH-1:1]}.
  - This is a logical right shift with si entering at the MSB.
  - The old rshift[0] is discarded.
- so is a combinational copy of rshift[0], with no extra register stage.
- There is no enable: the register shifts on every non-reset edge.
- There is no load, no direction control and no handshake.
- The block has no state beyond rshift and no state machine.
- Power-up contents are undefined until the first reset edge. The bench always applies reset first.
- When rst is asserted mid-stream, all in-flight bits are discarded on that edge. Shifting resumes on the first edge with rst=0.
- When rst and si change together, rst has priority.

## Timing
- A bit sampled on edge N appears at rshift[WIDTH-1] after edge N. It appears on so after edge N+WIDTH-1.
- For WIDTH=4, a bit becomes visible on so 3 edges after it is sampled, i.e. 4 edges including its own sampling edge.
- Outputs change only just after rising clk edges. There is no combinational path from si to any output.
- Reset is synchronous: asserting rst between edges has no effect until the next rising edge.
- Reset latency is 1 edge; after it, rshift=0 and so=0.
- si must be stable around the rising edge. Stimulus changes si on the falling edge or mid-cycle.

## Test plan
- Reset: hold rst=1 for one rising edge with si=0 -> rshift=0000, so=0.
- Shift sequence: after reset, drive si = 0,1,1,0,1,1 on successive edges.
  - rshift must read 0000, 1000, 1100, 0110, 1011, 1101.
  - so must read 0, 0, 0, 0, 1, 1.
- Latency: reset, then a single 1 followed by 0s -> rshift walks 1000, 0100, 0010, 0001, 0000. so=1 only after the 4th edge.
- All ones: after reset, si=1 for 5 edges -> rshift fills 1000, 1100, 1110, 1111, 1111. so rises after the 4th edge.
- Mid-stream reset: with rshift=1101, assert rst=1 and si=1 for one edge -> rshift=0000, so=0. With rst=0 and si=1 on the next edge -> rshift=1000.
- Asynchronous-glitch check: pulse rst high then low entirely between two rising edges -> rshift and so are unchanged and the shift proceeds normally.
